// File: rtl/ucode_seq_ctrl.sv
// Microcode sequencer: 13-state walk with two cond-indexed dispatch tables, stall watchdog and abort.
// One transition per cycle when busy; dispatch states wait on cond_valid (cond_ack same cycle).
module ucode_seq_ctrl #(
   parameter int STALL_LIMIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] cond,
   input  logic       cond_valid,
   output logic       cond_ack,
   input  logic       cfg_we,
   input  logic       cfg_sel,
   input  logic [1:0] cfg_addr,
   input  logic [3:0] cfg_data,
   output logic [3:0] state,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] step_count
);

   localparam int SW = $clog2(STALL_LIMIT + 1);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);

   localparam logic [3:0] S0  = 4'd0;
   localparam logic [3:0] S1  = 4'd1;
   localparam logic [3:0] S2  = 4'd2;
   localparam logic [3:0] S3  = 4'd3;
   localparam logic [3:0] S4  = 4'd4;
   localparam logic [3:0] S5  = 4'd5;
   localparam logic [3:0] S6  = 4'd6;
   localparam logic [3:0] S7  = 4'd7;
   localparam logic [3:0] S8  = 4'd8;
   localparam logic [3:0] S9  = 4'd9;
   localparam logic [3:0] S10 = 4'd10;
   localparam logic [3:0] S11 = 4'd11;
   localparam logic [3:0] S12 = 4'd12;

   logic [3:0]    tab_a [4];
   logic [3:0]    tab_b [4];
   logic [SW-1:0] stall_cnt;
   logic [3:0]    next_state;
   logic          is_disp;
   logic          is_term;
   logic          bad_tgt;
   logic [7:0]    step_inc;

   always_comb begin
      next_state = S0;
      case (state)
         S0, S1, S2, S6, S7, S8, S9: next_state = state + 4'd1;
         S3:                         next_state = tab_a[cond];
         S4, S5:                     next_state = S7;
         S10:                        next_state = tab_b[cond];
         default:                    next_state = S0;
      endcase
   end

   assign is_disp  = (state == S3) || (state == S10);
   assign is_term  = (state == S11) || (state == S12);
   // only table contents can name a state beyond S12
   assign bad_tgt  = next_state > S12;
   assign cond_ack = busy & cond_valid & is_disp;
   assign step_inc = (step_count == 8'hFF) ? step_count : step_count + 8'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         step_count <= 8'd0;
         stall_cnt  <= '0;
         tab_a[0]   <= 4'd4;
         tab_a[1]   <= 4'd5;
         tab_a[2]   <= 4'd6;
         tab_a[3]   <= 4'd6;
         tab_b[0]   <= 4'd11;
         tab_b[1]   <= 4'd12;
         tab_b[2]   <= 4'd12;
         tab_b[3]   <= 4'd12;
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (start) begin
               busy       <= 1'b1;
               state      <= S0;
               step_count <= 8'd0;
               err        <= 1'b0;
               stall_cnt  <= '0;
            end
            if (cfg_we) begin
               if (cfg_sel) tab_b[cfg_addr] <= cfg_data;
               else         tab_a[cfg_addr] <= cfg_data;
            end
         end else if (is_disp && !cond_valid) begin
            if (stall_cnt == STALL_LAST) begin
               err       <= 1'b1;
               busy      <= 1'b0;
               state     <= S0;
               stall_cnt <= '0;
            end else begin
               stall_cnt <= stall_cnt + SW'(1);
            end
         end else if (bad_tgt) begin
            // abort keeps step_count so software can see how far the pass got
            err       <= 1'b1;
            busy      <= 1'b0;
            state     <= S0;
            stall_cnt <= '0;
         end else begin
            state      <= next_state;
            step_count <= step_inc;
            stall_cnt  <= '0;
            if (is_term) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ucode_seq_ctrl.sv
// Bench for ucode_seq_ctrl: table of pass scenarios with a scoreboard, plus hand-written corner sequences.
module tb_ucode_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [1:0] cond = 2'd0;
   logic       cond_valid = 1'b0;
   logic       cond_ack;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [1:0] cfg_addr = 2'd0;
   logic [3:0] cfg_data = 4'd0;
   logic [3:0] state;
   logic       busy;
   logic       done;
   logic       err;
   logic [7:0] step_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ucode_seq_ctrl #(.STALL_LIMIT(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cond       (cond),
      .cond_valid (cond_valid),
      .cond_ack   (cond_ack),
      .cfg_we     (cfg_we),
      .cfg_sel    (cfg_sel),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .state      (state),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .step_count (step_count)
   );

   typedef struct {
      int do_reset;
      int wr_en;
      int wr_with_start;
      int wr_sel;
      int wr_addr;
      int wr_data;
      int busy_wr;
      int busy_start;
      int cond_a;
      int cond_b;
      int stall_a;
      int stall_b;
      int exp_err;
      int exp_steps;
      int exp_acks;
      int exp_term;
   } vec_t;

   typedef struct {
      int err;
      int steps;
      int acks;
      int term;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[10];
   vec_t last_vec;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cfg(input int sel, input int addr, input int data);
      cfg_we   = 1'b1;
      cfg_sel  = 1'(sel);
      cfg_addr = 2'(addr);
      cfg_data = 4'(data);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int   sc_a;
      int   sc_b;
      int   acks;
      int   term;
      int   exp_ack;
      logic ended;
      exp_t e;
      sc_a  = 0;
      sc_b  = 0;
      acks  = 0;
      term  = 0;
      ended = 1'b0;
      if (v.do_reset != 0) begin
         reset = 1'b1;
         tick();
         reset = 1'b0;
      end
      if (v.wr_en != 0 && v.wr_with_start == 0) begin
         drive_cfg(v.wr_sel, v.wr_addr, v.wr_data);
         tick();
         cfg_we = 1'b0;
      end
      start = 1'b1;
      if (v.wr_en != 0 && v.wr_with_start != 0) drive_cfg(v.wr_sel, v.wr_addr, v.wr_data);
      tick();
      start  = 1'b0;
      cfg_we = 1'b0;
      sb.push_back('{v.exp_err, v.exp_steps, v.exp_acks, v.exp_term});
      for (int cyc = 0; cyc < 200 && !ended; cyc++) begin
         if (!busy) begin
            ended      = 1'b1;
            start      = 1'b0;
            cfg_we     = 1'b0;
            cond_valid = 1'b0;
         end else begin
            cond_valid = 1'($urandom_range(0, 1));
            cond       = 2'($urandom_range(0, 3));
            start      = (v.busy_start != 0);
            if (v.busy_wr != 0) drive_cfg(1, 0, 14);
            else cfg_we = 1'b0;
            if (state == 4'd3) begin
               if (sc_a < v.stall_a) begin
                  cond_valid = 1'b0;
                  sc_a++;
               end else begin
                  cond_valid = 1'b1;
                  cond       = 2'(v.cond_a);
               end
            end else if (state == 4'd10) begin
               if (sc_b < v.stall_b) begin
                  cond_valid = 1'b0;
                  sc_b++;
               end else begin
                  cond_valid = 1'b1;
                  cond       = 2'(v.cond_b);
               end
            end
            if (state == 4'd11 || state == 4'd12) term = int'(state);
            exp_ack = ((state == 4'd3 || state == 4'd10) && cond_valid) ? 1 : 0;
            #1;
            chk($sformatf("%s_cond_ack_s%0d", nm, state), int'(cond_ack), exp_ack);
            if (cond_ack) acks++;
            tick();
         end
      end
      start      = 1'b0;
      cfg_we     = 1'b0;
      cond_valid = 1'b0;
      if (!ended) chk({nm, "_pass_timeout"}, 0, 1);
      if (sb.size() == 0) begin
         chk({nm, "_scoreboard_empty"}, 0, 1);
      end else begin
         e = sb.pop_front();
         chk({nm, "_err"}, int'(err), e.err);
         chk({nm, "_step_count"}, int'(step_count), e.steps);
         chk({nm, "_ack_count"}, acks, e.acks);
         chk({nm, "_terminal"}, term, e.term);
         chk({nm, "_state_idle"}, int'(state), 0);
         chk({nm, "_done"}, int'(done), (e.err != 0) ? 0 : 1);
         tick();
         chk({nm, "_done_width"}, int'(done), 0);
         chk({nm, "_err_sticky"}, int'(err), e.err);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int   seq[11];
      logic found;
      seq = '{0, 1, 2, 3, 4, 7, 8, 9, 10, 11, 0};

      vecs[0] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0, 10, 2, 11};
      vecs[1] = '{0, 0, 0, 0, 0, 0,  0, 0, 2, 3, 0,  0,  0, 10, 2, 12};
      vecs[2] = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0,  0,  0, 10, 2, 12};
      vecs[3] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 16, 0,  1, 3,  0, 0};
      vecs[4] = '{0, 0, 0, 0, 0, 0,  0, 0, 3, 0, 15, 0,  0, 10, 2, 11};
      vecs[5] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 10, 10, 0, 10, 2, 12};
      vecs[6] = '{0, 1, 0, 1, 1, 13, 1, 0, 0, 1, 0,  0,  1, 8,  2, 0};
      vecs[7] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0,  0, 10, 2, 11};
      vecs[8] = '{0, 1, 1, 0, 0, 12, 0, 0, 0, 0, 0,  0,  0, 5,  1, 12};
      vecs[9] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  0,  0, 10, 2, 12};
      last_vec = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0,  0,  0, 10, 2, 12};

      tick();
      tick();
      reset = 1'b0;
      chk("reset_state", int'(state), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_step_count", int'(step_count), 0);
      tick();
      chk("idle_state_hold", int'(state), 0);

      // default tables, cond=0 always valid: exact path and done timing
      start      = 1'b1;
      cond       = 2'd0;
      cond_valid = 1'b1;
      tick();
      start = 1'b0;
      chk("seq_busy_first", int'(busy), 1);
      chk("seq_step_first", int'(step_count), 0);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("seq_state_%0d", i), int'(state), seq[i]);
         chk($sformatf("seq_done_%0d", i), int'(done), (i == 10) ? 1 : 0);
         if (i == 10) begin
            chk("seq_busy_end", int'(busy), 0);
            chk("seq_step_end", int'(step_count), 10);
            chk("seq_err_end", int'(err), 0);
         end
         tick();
      end
      cond_valid = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // corrupt A[2], then reset mid-pass at S8 while also hitting start and a B write
      drive_cfg(0, 2, 15);
      tick();
      cfg_we = 1'b0;
      start  = 1'b1;
      tick();
      start      = 1'b0;
      cond       = 2'd0;
      cond_valid = 1'b1;
      found      = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (state == 4'd8) found = 1'b1;
         else tick();
      end
      chk("midreset_reach_s8", int'(found), 1);
      reset = 1'b1;
      start = 1'b1;
      drive_cfg(1, 3, 15);
      tick();
      reset      = 1'b0;
      start      = 1'b0;
      cfg_we     = 1'b0;
      cond_valid = 1'b0;
      chk("midreset_state", int'(state), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_step_count", int'(step_count), 0);
      chk("midreset_done", int'(done), 0);
      tick();
      run_vec(last_vec, "after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
